axi4_wr_slave: RTL and testbench
================================

AXI4_WR_SLAVE -- requirements
Module: axi4_wr_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-002 SHALL have parameter DATA_W, default 32: write data width; legal values are 32, 64 and 128.
REQ-003 SHALL have parameter ID_W, default 4: transaction ID width.
REQ-004 SHALL have port ACLK, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-005 SHALL have port ARESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port aw, axi4_aw_if.slave modport: write address channel in.
REQ-007 SHALL have port w, axi4_w_if.slave modport: write data channel in.
REQ-008 SHALL have port b, axi4_b_if.slave modport: write response channel out.
REQ-009 SHALL have port mem_we, output, 1 bit: memory write strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits: memory byte address, aligned to DATA_W.
REQ-011 SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-012 SHALL have port mem_wstrb, output, DATA_W/8 bits: memory byte enables.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, DATA and RESP.
REQ-014 SHALL assert AWREADY only in IDLE and hold WREADY and BVALID low in IDLE.
- On an AW handshake it captures AWID, AWADDR, AWLEN, AWSIZE and AWBURST, then goes to DATA.
REQ-015 SHALL, in DATA, assert WREADY and hold AWREADY low.
- Each W handshake is one beat and increments an 8-bit beat counter.
- The beat where the counter equals the captured AWLEN is the final beat; it moves the FSM to RESP.
REQ-016 SHALL issue each memory write exactly 1 cycle after its W handshake.
- mem_we is high for exactly one cycle per beat.
- mem_addr, mem_wdata and mem_wstrb come from the registered beat address, WDATA and WSTRB.
REQ-017 SHALL update the beat address after each beat according to the burst type.
- FIXED (00): address unchanged.
- INCR (01): address + (1 << AWSIZE).
- WRAP (10): address + (1 << AWSIZE), wrapped modulo (AWLEN+1) << AWSIZE within the aligned wrap boundary.
REQ-018 SHALL flag an error, return BRESP=SLVERR (2'b10) and suppress all mem_we pulses for the burst on any of these conditions:
- AWBURST = 11;
- AWSIZE > log2(DATA_W/8);
- WRAP with AWLEN not in {1, 3, 7, 15};
- WRAP with an unaligned AWADDR.
REQ-019 SHALL handle WLAST mismatch as follows.
- WLAST high before the final beat: set BRESP=SLVERR, keep the write, continue the burst.
- WLAST low on the final beat: set BRESP=SLVERR, keep the write, end the burst.
REQ-020 SHALL, in RESP, hold BVALID high with the captured ID on BID and BRESP (OKAY = 00 unless flagged) stable until BREADY.
- The FSM returns to IDLE on the cycle after the B handshake.
- AWREADY is therefore 0 in the handshake cycle itself.
REQ-021 SHALL drive BUSER to 0.
REQ-022 SHALL ignore AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER, WID and WUSER.
REQ-023 SHALL make mem_addr wrap modulo 2^ADDR_W at the top of the address space; no error is raised.

Reset
REQ-024 SHALL, while ARESET is high, force the FSM to IDLE and all flags and counters to 0.
REQ-025 SHALL drive these outputs to 0 during reset: AWREADY, WREADY, BVALID, BID, BRESP, mem_we, mem_addr, mem_wdata and mem_wstrb.
REQ-026 SHALL, when reset is asserted mid-burst, abandon the burst with no B response and no further mem_we.
- The first AW is accepted in the cycle after ARESET deasserts.

Structure
REQ-027 SHALL take the burst-type constants, the response constants (OKAY, SLVERR) and the FSM state enum from shared package axi4_pkg.
REQ-028 SHALL place the FIXED/INCR/WRAP next-address arithmetic in combinational sub-module axi4_burst_addr, which is reused by the future read slave.

Verification
REQ-029 SHALL cover: INCR, AWADDR=0x100, AWLEN=3, AWSIZE=2, AWID=5 -> mem_addr 0x100, 0x104, 0x108, 0x10C; then BID=5, BRESP=00.
REQ-030 SHALL cover: WRAP, AWADDR=0x108, AWLEN=3, AWSIZE=2 -> mem_addr 0x108, 0x10C, 0x100, 0x104.
REQ-031 SHALL cover: FIXED, AWADDR=0x20, AWLEN=2, WSTRB=0x3 -> three mem_we pulses, all at 0x20 with wstrb 0x3.
REQ-032 SHALL cover: AWBURST=11, AWLEN=1 -> two WREADY beats, zero mem_we, BRESP=10.
REQ-033 SHALL cover: AWLEN=3 with WLAST on beat 1 -> 4 writes, BRESP=10; and BREADY held low for 5 cycles -> BVALID, BID and BRESP stable, AWREADY=0.
REQ-034 SHALL cover: ARESET pulsed after beat 2 of an AWLEN=7 burst -> no BVALID, no further mem_we, and AWREADY=1 the next cycle.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings: burst types, response codes and the write-slave FSM states.
// Shared by the write slave and the planned read slave.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } slv_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_wr_slave_if.sv
// AXI4 write-path channel interfaces (AW, W, B).
// Each interface has a master and a slave modport.
interface axi4_aw_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWLOCK;
  logic [3:0]        AWCACHE;
  logic [2:0]        AWPROT;
  logic [3:0]        AWQOS;
  logic [3:0]        AWREGION;
  logic              AWUSER;
  logic              AWVALID;
  logic              AWREADY;

  modport master (output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE,
                  AWPROT, AWQOS, AWREGION, AWUSER, AWVALID, input AWREADY);
  modport slave  (input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE,
                  AWPROT, AWQOS, AWREGION, AWUSER, AWVALID, output AWREADY);
endinterface

interface axi4_w_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     WID;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WUSER;
  logic                WVALID;
  logic                WREADY;

  modport master (output WID, WDATA, WSTRB, WLAST, WUSER, WVALID, input WREADY);
  modport slave  (input WID, WDATA, WSTRB, WLAST, WUSER, WVALID, output WREADY);
endinterface

interface axi4_b_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BUSER;
  logic            BVALID;
  logic            BREADY;

  modport master (input BID, BRESP, BUSER, BVALID, output BREADY);
  modport slave  (output BID, BRESP, BUSER, BVALID, input BREADY);
endinterface

// File: rtl/axi4_burst_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// Shared with the read slave.
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next_addr
);

  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_sum;
  logic [ADDR_W-1:0] w_wrap_mask;

  always_comb begin
    w_incr      = ADDR_W'(1) << i_size;
    w_sum       = i_addr + w_incr;
    // Wrap window is (len+1) beats of 2^size bytes; only legal lengths reach here.
    w_wrap_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
    case (i_burst)
      BURST_INCR: o_next_addr = w_sum;
      BURST_WRAP: o_next_addr = (i_addr & ~w_wrap_mask) | (w_sum & w_wrap_mask);
      default:    o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/axi4_wr_slave.sv
// AXI4 write slave: one burst at a time, each accepted beat becomes a
// single-cycle memory write one clock later, followed by one B response.
module axi4_wr_slave
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi4_aw_if.slave            aw,
  axi4_w_if.slave             w,
  axi4_b_if.slave             b,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  localparam int                STRB_W   = DATA_W / 8;
  localparam int                SIZE_MAX = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] BUS_MASK = ADDR_W'(STRB_W - 1);

  slv_state_e          r_state;
  slv_state_e          w_next_state;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [7:0]          r_cnt;
  logic                r_drop;
  logic                r_slverr;
  logic                r_mem_we_p1;
  logic [ADDR_W-1:0]   r_mem_addr_p1;
  logic [DATA_W-1:0]   r_mem_wdata_p1;
  logic [STRB_W-1:0]   r_mem_wstrb_p1;

  logic                w_awready;
  logic                w_wready;
  logic                w_bvalid;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_final;
  logic                w_dec_err;
  logic [ADDR_W-1:0]   w_size_mask;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_unused;

  assign w_unused = ^{aw.AWLOCK, aw.AWCACHE, aw.AWPROT, aw.AWQOS, aw.AWREGION,
                      aw.AWUSER, w.WID, w.WUSER};

  axi4_burst_addr #(.ADDR_W(ADDR_W)) u_burst_addr (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  // Illegal bursts are still drained beat by beat but never reach memory.
  assign w_size_mask = (ADDR_W'(1) << aw.AWSIZE) - ADDR_W'(1);
  assign w_dec_err   = (aw.AWBURST == 2'b11) ||
                       (aw.AWSIZE > 3'(SIZE_MAX)) ||
                       ((aw.AWBURST == BURST_WRAP) &&
                        (!wrap_len_ok(aw.AWLEN) || ((aw.AWADDR & w_size_mask) != '0)));

  assign w_final = (r_cnt == r_len);
  assign w_aw_hs = w_awready & aw.AWVALID;
  assign w_w_hs  = w_wready & w.WVALID;

  always_comb begin
    w_next_state = r_state;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_awready = 1'b1;
        if (aw.AWVALID) w_next_state = ST_DATA;
      end
      ST_DATA: begin
        w_wready = 1'b1;
        if (w.WVALID && w_final) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        w_bvalid = 1'b1;
        if (b.BREADY) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state        <= ST_IDLE;
      r_id           <= '0;
      r_addr         <= '0;
      r_len          <= '0;
      r_size         <= '0;
      r_burst        <= '0;
      r_cnt          <= '0;
      r_drop         <= 1'b0;
      r_slverr       <= 1'b0;
      r_mem_we_p1    <= 1'b0;
      r_mem_addr_p1  <= '0;
      r_mem_wdata_p1 <= '0;
      r_mem_wstrb_p1 <= '0;
    end else begin
      r_state     <= w_next_state;
      r_mem_we_p1 <= w_w_hs & ~r_drop;
      if (w_aw_hs) begin
        r_id     <= aw.AWID;
        r_addr   <= aw.AWADDR;
        r_len    <= aw.AWLEN;
        r_size   <= aw.AWSIZE;
        r_burst  <= aw.AWBURST;
        r_cnt    <= '0;
        r_drop   <= w_dec_err;
        r_slverr <= w_dec_err;
      end
      // Stage p1: beat captured here appears on the memory port next cycle.
      if (w_w_hs) begin
        r_cnt          <= r_cnt + 8'd1;
        r_addr         <= w_next_addr;
        r_mem_addr_p1  <= r_addr & ~BUS_MASK;
        r_mem_wdata_p1 <= w.WDATA;
        r_mem_wstrb_p1 <= w.WSTRB;
        if (w.WLAST != w_final) r_slverr <= 1'b1;
      end
    end
  end

  // Outputs are gated so they read zero in the very cycle reset is applied.
  assign aw.AWREADY = w_awready & ~ARESET;
  assign w.WREADY   = w_wready & ~ARESET;
  assign b.BVALID   = w_bvalid & ~ARESET;
  assign b.BID      = ARESET ? '0 : r_id;
  assign b.BRESP    = (ARESET || !r_slverr) ? RESP_OKAY : RESP_SLVERR;
  assign b.BUSER    = 1'b0;
  assign mem_we     = r_mem_we_p1 & ~ARESET;
  assign mem_addr   = ARESET ? '0 : r_mem_addr_p1;
  assign mem_wdata  = ARESET ? '0 : r_mem_wdata_p1;
  assign mem_wstrb  = ARESET ? '0 : r_mem_wstrb_p1;

endmodule

// File: tb/tb_axi4_wr_slave.sv
// Scoreboard bench for axi4_wr_slave: directed scenarios plus randomized bursts
// checked against an address/response model built from the burst rules.
`timescale 1ns/1ps
module tb_axi4_wr_slave;
  import axi4_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;

  axi4_aw_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) aw();
  axi4_w_if  #(.DATA_W(DATA_W), .ID_W(ID_W)) w();
  axi4_b_if  #(.ID_W(ID_W))                  b();

  axi4_wr_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .aw        (aw),
    .w         (w),
    .b         (b),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;

  wr_t exp_wr[$];
  b_t  exp_b[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL timeout_%s: actual=no handshake required=handshake within 50 cycles", name);
  endtask

  // Reference model: beat address from burst rules, then aligned to the bus.
  function automatic logic [31:0] model_addr(input logic [31:0] start, input int len,
                                             input int size, input logic [1:0] bt, input int i);
    logic [31:0] nb, a, wb, lo;
    nb = 32'(1) << size;
    case (bt)
      2'b01: a = start + 32'(i) * nb;
      2'b10: begin
        wb = 32'(len + 1) * nb;
        lo = (start / wb) * wb;
        a  = lo + ((start - lo) + 32'(i) * nb) % wb;
      end
      default: a = start;
    endcase
    return a & ~32'(STRB_W - 1);
  endfunction

  function automatic bit model_err(input logic [31:0] start, input int len,
                                   input int size, input logic [1:0] bt);
    if (bt == 2'b11) return 1'b1;
    if (size > $clog2(STRB_W)) return 1'b1;
    if (bt == 2'b10 && !(len inside {1, 3, 7, 15})) return 1'b1;
    if (bt == 2'b10 && (start % (32'(1) << size)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a write or a response.
  always @(negedge ACLK) begin
    wr_t e;
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mem_we_unexpected: actual addr=%0h required=no write", mem_addr);
      end else begin
        e = exp_wr.pop_front();
        check("mem_addr",  64'(mem_addr),  64'(e.addr));
        check("mem_wdata", 64'(mem_wdata), 64'(e.data));
        check("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
      end
    end
    if (b.BVALID) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bvalid_unexpected: actual bid=%0h required=no response", b.BID);
      end else begin
        check("bid",             64'(b.BID),      64'(exp_b[0].id));
        check("bresp",           64'(b.BRESP),    64'(exp_b[0].resp));
        check("buser",           64'(b.BUSER),    64'd0);
        check("awready_in_resp", 64'(aw.AWREADY), 64'd0);
        if (b.BREADY) void'(exp_b.pop_front());
      end
    end
  end

  task automatic send_aw(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] bt);
    bit got;
    got = 1'b0;
    aw.AWID = id; aw.AWADDR = a; aw.AWLEN = len; aw.AWSIZE = size; aw.AWBURST = bt;
    aw.AWLOCK = 1'($urandom); aw.AWCACHE = 4'($urandom); aw.AWPROT = 3'($urandom);
    aw.AWQOS = 4'($urandom); aw.AWREGION = 4'($urandom); aw.AWUSER = 1'($urandom);
    aw.AWVALID = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge ACLK);
      if (aw.AWREADY) got = 1'b1;
    end
    if (!got) timeout("awready");
    @(posedge ACLK); #1;
    aw.AWVALID = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input bit last, input int gap);
    bit got;
    got = 1'b0;
    repeat (gap) begin @(posedge ACLK); #1; end
    w.WDATA = d; w.WSTRB = s; w.WLAST = last;
    w.WID = 4'($urandom); w.WUSER = 1'($urandom); w.WVALID = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge ACLK);
      if (w.WREADY) got = 1'b1;
    end
    if (!got) timeout("wready");
    @(posedge ACLK); #1;
    w.WVALID = 1'b0;
  endtask

  task automatic recv_b(input int stall);
    bit got;
    got = 1'b0;
    b.BREADY = 1'b0;
    repeat (stall) begin @(posedge ACLK); #1; end
    b.BREADY = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge ACLK);
      if (b.BVALID) got = 1'b1;
    end
    if (!got) timeout("bvalid");
    @(posedge ACLK); #1;
    b.BREADY = 1'b0;
  endtask

  task automatic do_burst(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] bt, input logic [3:0] strb_fix,
                          input bit strb_rand, input int flip, input int bstall, input bit exp_we,
                          input logic [1:0] exp_resp, input logic [31:0] exp_addr[$]);
    send_aw(id, a, len, size, bt);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] d;
      logic [3:0]  s;
      bit          last;
      d    = $urandom;
      s    = strb_rand ? 4'($urandom) : strb_fix;
      last = (i == int'(len)) ^ (i == flip);
      if (exp_we) exp_wr.push_back(wr_t'{exp_addr[i], d, s});
      send_beat(d, s, last, strb_rand ? int'($urandom_range(0, 2)) : 0);
    end
    exp_b.push_back(b_t'{id, exp_resp});
    recv_b(bstall);
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", 64'(aw.AWREADY), 64'd0);
    check("rst_wready",  64'(w.WREADY),   64'd0);
    check("rst_bvalid",  64'(b.BVALID),   64'd0);
    check("rst_bid",     64'(b.BID),      64'd0);
    check("rst_bresp",   64'(b.BRESP),    64'd0);
    check("rst_mem_we",  64'(mem_we),     64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=simulation still running required=finish within 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] d0, d1;
    aw.AWVALID = 1'b0; aw.AWID = '0; aw.AWADDR = '0; aw.AWLEN = '0; aw.AWSIZE = '0;
    aw.AWBURST = '0; aw.AWLOCK = 1'b0; aw.AWCACHE = '0; aw.AWPROT = '0; aw.AWQOS = '0;
    aw.AWREGION = '0; aw.AWUSER = 1'b0;
    w.WVALID = 1'b0; w.WDATA = '0; w.WSTRB = '0; w.WLAST = 1'b0; w.WID = '0; w.WUSER = 1'b0;
    b.BREADY = 1'b0;

    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("awready_after_reset", 64'(aw.AWREADY), 64'd1);
    @(posedge ACLK); #1;

    q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    do_burst(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF, 1'b1, -1, 0, 1'b1, 2'b00, q);

    q = '{32'h108, 32'h10C, 32'h100, 32'h104};
    do_burst(4'd3, 32'h108, 8'd3, 3'd2, 2'b10, 4'hF, 1'b1, -1, 1, 1'b1, 2'b00, q);

    q = '{32'h20, 32'h20, 32'h20};
    do_burst(4'd9, 32'h20, 8'd2, 3'd2, 2'b00, 4'h3, 1'b0, -1, 0, 1'b1, 2'b00, q);

    q = {};
    do_burst(4'd1, 32'h40, 8'd1, 3'd2, 2'b11, 4'hF, 1'b0, -1, 0, 1'b0, 2'b10, q);

    q = '{32'h40, 32'h44, 32'h48, 32'h4C};
    do_burst(4'd12, 32'h40, 8'd3, 3'd2, 2'b01, 4'hF, 1'b0, 1, 5, 1'b1, 2'b10, q);

    // Reset in the middle of an 8-beat burst, after two beats have landed.
    send_aw(4'd7, 32'h200, 8'd7, 3'd2, 2'b01);
    d0 = $urandom;
    d1 = $urandom;
    exp_wr.push_back(wr_t'{32'h200, d0, 4'hF});
    send_beat(d0, 4'hF, 1'b0, 0);
    exp_wr.push_back(wr_t'{32'h204, d1, 4'hF});
    send_beat(d1, 4'hF, 1'b0, 0);
    @(negedge ACLK); #1;
    ARESET = 1'b1;
    w.WDATA = $urandom; w.WSTRB = 4'hF; w.WLAST = 1'b0; w.WVALID = 1'b1;
    @(negedge ACLK);
    check_reset_outputs();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("awready_after_abort", 64'(aw.AWREADY), 64'd1);
    check("wready_after_abort",  64'(w.WREADY),   64'd0);
    @(posedge ACLK); #1;
    w.WVALID = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      check("bvalid_after_abort", 64'(b.BVALID), 64'd0);
    end
    @(posedge ACLK); #1;

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [1:0]  bt;
      int          size, len, flip;
      bit          er;
      if ($urandom_range(0, 7) == 0) bt = 2'b11;
      else bt = 2'($urandom_range(0, 2));
      size = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      if (bt == 2'b10 && $urandom_range(0, 5) != 0) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = int'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else a = $urandom;
      if ($urandom_range(0, 5) != 0) a = a & ~((32'(1) << size) - 32'd1);
      flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
      er = model_err(a, len, size, bt);
      q = {};
      for (int i = 0; i <= len; i++) q.push_back(model_addr(a, len, size, bt, i));
      do_burst(4'($urandom), a, 8'(len), 3'(size), bt, 4'hF, 1'b1, flip,
               int'($urandom_range(0, 3)), !er, (er || flip >= 0) ? 2'b10 : 2'b00, q);
    end

    repeat (5) @(posedge ACLK);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("b_queue_empty",  64'(exp_b.size()),  64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
